// File: rtl/btb_pkg.sv
// Shared types for the branch target buffer: counter encodings, defaults and the entry layout.
// The tag field is sized for the widest legal tag; narrower tags are stored zero-extended.
package btb_pkg;

  localparam int BTB_ENTRIES_DEF = 16;
  localparam int BTB_TAG_W_DEF   = 10;
  localparam int BTB_TAG_MAX     = 30;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } btb_ctr_e;

  typedef struct packed {
    logic                   valid;
    logic [BTB_TAG_MAX-1:0] tag;
    logic [31:0]            target;
    btb_ctr_e               ctr;
  } btb_entry_t;

  function automatic btb_entry_t btb_entry_reset();
    btb_entry_t e;
    e.valid  = 1'b0;
    e.tag    = '0;
    e.target = '0;
    e.ctr    = CTR_WNT;
    return e;
  endfunction

endpackage

// File: rtl/btb_sat_ctr.sv
// 2-bit saturating direction counter next-state function (combinational).
module btb_sat_ctr
  import btb_pkg::*;
(
  input  btb_ctr_e ctr,
  input  logic     taken,
  output btb_ctr_e ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken && (ctr != CTR_ST)) begin
      ctr_next = btb_ctr_e'(ctr + 2'd1);
    end else if (!taken && (ctr != CTR_SNT)) begin
      ctr_next = btb_ctr_e'(ctr - 2'd1);
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped fetch-stage BTB with 2-bit direction counters, trained from E/M.
// Optional BTB_STATS_EN adds saturating lookup/hit/mispredict counters.
module btb_predictor
  import btb_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES_DEF,
  parameter int TAG_W   = BTB_TAG_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_is_jump,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispred
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_mispred
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);

  btb_entry_t mem [ENTRIES];

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  btb_entry_t       f_ent;

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[TAG_W+IDX_W+1:IDX_W+2];
  assign f_ent = mem[f_idx];

  // Lookup reads the pre-edge array contents; no bypass from the update path.
  always_comb begin
    pred_hit    = f_ent.valid && (f_ent.tag == BTB_TAG_MAX'(f_tag));
    pred_taken  = pred_hit && f_ent.ctr[1];
    pred_target = pred_taken ? f_ent.target : (fetch_pc + 32'd4);
  end

  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  btb_entry_t       u_ent;
  logic             u_hit;
  logic             u_taken;
  btb_ctr_e         u_ctr_next;
  btb_entry_t       u_new;
  logic             u_we;

  assign u_idx   = upd_pc[IDX_W+1:2];
  assign u_tag   = upd_pc[TAG_W+IDX_W+1:IDX_W+2];
  assign u_ent   = mem[u_idx];
  assign u_hit   = u_ent.valid && (u_ent.tag == BTB_TAG_MAX'(u_tag));
  assign u_taken = upd_taken || upd_is_jump;

  btb_sat_ctr u_sat_ctr (
    .ctr      (u_ent.ctr),
    .taken    (u_taken),
    .ctr_next (u_ctr_next)
  );

  always_comb begin
    u_we  = 1'b0;
    u_new = u_ent;
    if (upd_valid) begin
      if (u_hit) begin
        u_we      = 1'b1;
        u_new.ctr = upd_is_jump ? CTR_ST : u_ctr_next;
        if (u_taken) begin
          u_new.target = upd_target;
        end
      end else if (u_taken) begin
        // Only taken outcomes allocate; not-taken misses leave the entry alone.
        u_we         = 1'b1;
        u_new.valid  = 1'b1;
        u_new.tag    = BTB_TAG_MAX'(u_tag);
        u_new.target = upd_target;
        u_new.ctr    = upd_is_jump ? CTR_ST : CTR_WT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < ENTRIES; k++) begin
        mem[k] <= btb_entry_reset();
      end
    end else if (u_we) begin
      mem[u_idx] <= u_new;
    end
  end

`ifdef BTB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_lookups <= '0;
      stat_hits    <= '0;
      stat_mispred <= '0;
    end else begin
      if (stat_lookups != 32'hFFFF_FFFF) begin
        stat_lookups <= stat_lookups + 32'd1;
      end
      if (pred_hit && (stat_hits != 32'hFFFF_FFFF)) begin
        stat_hits <= stat_hits + 32'd1;
      end
      if (upd_valid && upd_mispred && (stat_mispred != 32'hFFFF_FFFF)) begin
        stat_mispred <= stat_mispred + 32'd1;
      end
    end
  end

  logic unused_upd;
  assign unused_upd = ^{upd_pc[1:0], upd_pc >> (TAG_W + IDX_W + 2)};
`else
  logic unused_upd;
  assign unused_upd = ^{upd_pc[1:0], upd_pc >> (TAG_W + IDX_W + 2), upd_mispred};
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: directed scenarios plus randomized training
// compared every cycle against a table-level behavioural model.
`timescale 1ns/100ps
module tb_btb_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] fetch_pc = '0;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_is_jump = 1'b0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_mispred = 1'b0;
`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_hits;
  logic [31:0] stat_mispred;
`endif

  btb_predictor dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_pc    (fetch_pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_is_jump (upd_is_jump),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .upd_mispred (upd_mispred)
`ifdef BTB_STATS_EN
    ,
    .stat_lookups (stat_lookups),
    .stat_hits    (stat_hits),
    .stat_mispred (stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: 16 entries, index = (pc/4) mod 16, tag = (pc/64) mod 1024.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  bit [31:0]   m_tgt   [16];
  int          m_ctr   [16];
  bit [31:0]   m_lookups, m_hits, m_mis;

  function automatic int unsigned idx_of(bit [31:0] pc);
    return (pc / 4) % 16;
  endfunction

  function automatic int unsigned tag_of(bit [31:0] pc);
    return (pc / 64) % 1024;
  endfunction

  function automatic bit model_hit(bit [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit model_taken(bit [31:0] pc);
    return model_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic bit [31:0] model_target(bit [31:0] pc);
    return model_taken(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 16; k++) begin
        m_valid[k] = 1'b0; m_tag[k] = 0; m_tgt[k] = '0; m_ctr[k] = 1;
      end
      m_lookups = '0; m_hits = '0; m_mis = '0;
    end else begin
      if (m_lookups != 32'hFFFF_FFFF) m_lookups++;
      if (model_hit(fetch_pc) && m_hits != 32'hFFFF_FFFF) m_hits++;
      if (upd_valid && upd_mispred && m_mis != 32'hFFFF_FFFF) m_mis++;
      if (upd_valid) begin
        automatic int unsigned i = idx_of(upd_pc);
        automatic bit tk = upd_taken || upd_is_jump;
        if (model_hit(upd_pc)) begin
          if (tk) begin
            m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            m_tgt[i] = upd_target;
          end else begin
            m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
          end
          if (upd_is_jump) m_ctr[i] = 3;
        end else if (tk) begin
          m_valid[i] = 1'b1;
          m_tag[i]   = tag_of(upd_pc);
          m_tgt[i]   = upd_target;
          m_ctr[i]   = upd_is_jump ? 3 : 2;
        end
      end
    end
  end

  task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t fetch_pc=0x%08h)", name, act, exp, $time, fetch_pc);
    end
  endtask

  // Compare process: outputs are checked against the model mid-cycle, every cycle.
  always @(negedge clk) begin
    #2;
    check_val("model_hit",    32'(pred_hit),    32'(model_hit(fetch_pc)));
    check_val("model_taken",  32'(pred_taken),  32'(model_taken(fetch_pc)));
    check_val("model_target", pred_target,      model_target(fetch_pc));
`ifdef BTB_STATS_EN
    check_val("model_lookups", stat_lookups, m_lookups);
    check_val("model_hits",    stat_hits,    m_hits);
    check_val("model_mispred", stat_mispred, m_mis);
`endif
  end

  task automatic drive(bit v, bit [31:0] pc, bit j, bit t, bit [31:0] tgt, bit m, bit [31:0] fpc);
    upd_valid = v; upd_pc = pc; upd_is_jump = j; upd_taken = t;
    upd_target = tgt; upd_mispred = m; fetch_pc = fpc;
  endtask

  task automatic step(bit v, bit [31:0] pc, bit j, bit t, bit [31:0] tgt, bit m, bit [31:0] fpc);
    @(negedge clk);
    drive(v, pc, j, t, tgt, m, fpc);
  endtask

  task automatic expect_lit(string name, bit hit, bit tk, bit [31:0] tgt);
    check_val({name, "_hit"},    32'(pred_hit),   32'(hit));
    check_val({name, "_taken"},  32'(pred_taken), 32'(tk));
    check_val({name, "_target"}, pred_target,     tgt);
  endtask

  initial begin
    #1 rst = 1'b0;

    // Reset state
    step(0, 0, 0, 0, 0, 0, 32'h100);
    #3 expect_lit("reset", 0, 0, 32'h104);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
    #3 expect_lit("wrap", 0, 0, 32'h0);

    // Allocate taken branch, alias check at same index
    step(1, 32'h100, 0, 1, 32'h40, 0, 32'h100);
    #3 expect_lit("alloc_same_cycle", 0, 0, 32'h104);
    step(0, 0, 0, 0, 0, 0, 32'h100);
    #3 expect_lit("alloc_hit", 1, 1, 32'h40);
    step(0, 0, 0, 0, 0, 0, 32'h140);
    #3 expect_lit("alias_miss", 0, 0, 32'h144);

    // Three not-taken then two taken (low PC bits must be ignored)
    step(1, 32'h100, 0, 0, 32'h0, 0, 32'h0);
    step(1, 32'h101, 0, 0, 32'h0, 0, 32'h0);
    step(1, 32'h103, 0, 0, 32'h0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h100);
    #3 expect_lit("snt", 1, 0, 32'h104);
    step(1, 32'h100, 0, 1, 32'h40, 0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h100);
    #3 expect_lit("wnt", 1, 0, 32'h104);
    step(1, 32'h100, 0, 1, 32'h40, 0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h100);
    #3 expect_lit("wt_again", 1, 1, 32'h40);

    // Same-cycle update and lookup, then async reset mid-cycle
    step(1, 32'h100, 0, 0, 32'h0, 0, 32'h100);
    #3 expect_lit("same_cycle_old", 1, 1, 32'h40);
    step(0, 0, 0, 0, 0, 0, 32'h100);
    #3 expect_lit("same_cycle_new", 1, 0, 32'h104);
    rst = 1'b0;
    #1 expect_lit("mid_reset", 0, 0, 32'h104);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 32'h100);
    #3 expect_lit("after_reset", 0, 0, 32'h104);

    // Jump allocates at ST; not-taken miss never allocates
    step(1, 32'h200, 1, 1, 32'h800, 0, 32'h0);
    step(1, 32'h300, 0, 0, 32'h900, 0, 32'h0);
    step(1, 32'h200, 0, 0, 32'h0, 0, 32'h200);
    #3 expect_lit("jal_st", 1, 1, 32'h800);
    step(0, 0, 0, 0, 0, 0, 32'h200);
    #3 expect_lit("st_to_wt", 1, 1, 32'h800);
    step(0, 0, 0, 0, 0, 0, 32'h300);
    #3 expect_lit("nt_no_alloc", 0, 0, 32'h304);

    // Randomized training over a small tag pool so entries are reused and replaced
    for (int n = 0; n < 600; n++) begin
      automatic bit [31:0] tags[4] = '{32'd4, 32'd5, 32'd7, 32'd1023};
      automatic bit [31:0] upc = (tags[$urandom_range(0, 3)] << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      automatic bit [31:0] fpc = (tags[$urandom_range(0, 3)] << 6) | ($urandom_range(0, 15) << 2);
      automatic bit        j   = ($urandom_range(0, 3) == 0);
      automatic bit        t   = j ? 1'b1 : 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), upc, j, t, $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), fpc);
      if ($urandom_range(0, 149) == 0) begin
        #3 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end

`ifdef BTB_STATS_EN
    // 10 cycles out of reset: 4 hits, 2 mispredict pulses
    @(negedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    drive(1, 32'h100, 0, 1, 32'h40, 1, 32'h0);
    for (int n = 0; n < 4; n++) step(0, 0, 0, 0, 0, 0, 32'h100);
    step(1, 32'h300, 0, 0, 32'h0, 1, 32'h0);
    for (int n = 0; n < 4; n++) step(0, 0, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    #3;
    check_val("stat_lookups", stat_lookups, 32'd10);
    check_val("stat_hits",    stat_hits,    32'd4);
    check_val("stat_mispred", stat_mispred, 32'd2);
`endif

    @(negedge clk);
    #4;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
